// File: rtl/maq_pkg.sv
// Shared types, constants and helpers for the clock stages (hour, minute, seconds).
package maq_pkg;

    typedef logic [3:0] bcd_t;

    localparam int unsigned HOUR_MAX_MSD = 32'd2;
    localparam int unsigned HOUR_MAX_LSD = 32'd3;
    localparam int unsigned H12_MAX      = 32'd12;

    // Binary value (0..39) to two BCD digits {tens[1:0], units[3:0]}.
    function automatic logic [5:0] bin_to_bcd2(input int unsigned value);
        logic [1:0] tens;
        bcd_t       units;
        tens  = 2'(value / 32'd10);
        units = 4'(value % 32'd10);
        return {tens, units};
    endfunction

    // 24-h hour (0..23) to the 12-h dial value (1..12); midnight and noon read 12.
    function automatic int unsigned hour_24_to_12(input int unsigned hour);
        int unsigned h;
        h = hour % 32'd12;
        if (h == 32'd0) begin
            return H12_MAX;
        end else begin
            return h;
        end
    endfunction

endpackage

// File: rtl/maq_h_if.sv
// Hour-stage bus: increment/adjust/load requests in, BCD digits and flags out.
// With MAQH_12H_EN defined the bus also carries the maqh_pm indicator.
interface maq_h_if;
    import maq_pkg::*;

    logic       maqh_enable;
    logic       maqh_adjust;
    logic       maqh_load;
    bcd_t       maqh_load_lsd;
    logic [1:0] maqh_load_msd;
    bcd_t       maqh_lsd;
    logic [1:0] maqh_msd;
    logic       maqh_incrementadia;
    logic       maqh_load_err;
`ifdef MAQH_12H_EN
    logic       maqh_pm;
`endif

    modport master (
        output maqh_enable,
        output maqh_adjust,
        output maqh_load,
        output maqh_load_lsd,
        output maqh_load_msd,
        input  maqh_lsd,
        input  maqh_msd,
        input  maqh_incrementadia,
`ifdef MAQH_12H_EN
        input  maqh_pm,
`endif
        input  maqh_load_err
    );

    modport slave (
        input  maqh_enable,
        input  maqh_adjust,
        input  maqh_load,
        input  maqh_load_lsd,
        input  maqh_load_msd,
        output maqh_lsd,
        output maqh_msd,
        output maqh_incrementadia,
`ifdef MAQH_12H_EN
        output maqh_pm,
`endif
        output maqh_load_err
    );

endinterface

// File: rtl/maq_bcd_inc.sv
// Combinational two-digit BCD incrementer. At the wrap point (WRAP_MSD, WRAP_LSD)
// the result jumps to (WRAP_TO_MSD, WRAP_TO_LSD) and wrap is raised; otherwise
// the units digit counts 0..9 and carries into the tens digit.
module maq_bcd_inc
    import maq_pkg::*;
#(
    parameter int MSD_W       = 32'd2,
    parameter int WRAP_MSD    = 32'd2,
    parameter int WRAP_LSD    = 32'd3,
    parameter int WRAP_TO_MSD = 32'd0,
    parameter int WRAP_TO_LSD = 32'd0
) (
    input  logic [MSD_W-1:0] msd,
    input  bcd_t             lsd,
    output logic [MSD_W-1:0] next_msd,
    output bcd_t             next_lsd,
    output logic             wrap
);

    // Next value of the two digits, with wrap detection.
    always_comb begin
        wrap     = (msd == MSD_W'(WRAP_MSD)) && (lsd == 4'(WRAP_LSD));
        next_msd = msd;
        next_lsd = lsd;
        if (wrap) begin
            next_msd = MSD_W'(WRAP_TO_MSD);
            next_lsd = 4'(WRAP_TO_LSD);
        end else if (lsd == 4'd9) begin
            next_msd = msd + {{(MSD_W-1){1'b0}}, 1'b1};
            next_lsd = 4'd0;
        end else begin
            next_msd = msd;
            next_lsd = lsd + 4'd1;
        end
    end

endmodule

// File: rtl/maq_h.sv
// Hour stage of the digital clock: two BCD digits advanced by the minute stage's
// pulse or a manual adjust, with direct load from the front panel.
// Optional feature: define MAQH_12H_EN for a 12-h dial (12,01..11) with maqh_pm.
module maq_h
    import maq_pkg::*;
#(
    parameter int RESET_HOUR = 32'd0
) (
    input  logic    maqm_clock,
    input  logic    maqm_reset,
    maq_h_if.slave  bus
);

    if ((RESET_HOUR < 0) || (RESET_HOUR > 23)) begin : g_reset_hour_range
        $error("maq_h: RESET_HOUR must be in 0..23");
    end

`ifdef MAQH_12H_EN
    localparam logic [5:0] RESET_BCD   = bin_to_bcd2(hour_24_to_12(RESET_HOUR));
    localparam logic       RESET_PM    = (RESET_HOUR >= 32'sd12);
    localparam int         WRAP_MSD    = 32'd1;
    localparam int         WRAP_LSD    = 32'd2;
    localparam int         WRAP_TO_MSD = 32'd0;
    localparam int         WRAP_TO_LSD = 32'd1;
`else
    localparam logic [5:0] RESET_BCD   = bin_to_bcd2(RESET_HOUR);
    localparam int         WRAP_MSD    = HOUR_MAX_MSD;
    localparam int         WRAP_LSD    = HOUR_MAX_LSD;
    localparam int         WRAP_TO_MSD = 32'd0;
    localparam int         WRAP_TO_LSD = 32'd0;
`endif

    logic [1:0] msd_r;
    bcd_t       lsd_r;
    logic       load_err_r;
    logic [1:0] next_msd_s;
    bcd_t       next_lsd_s;
    logic       wrap_s;
    logic       load_valid_s;
    logic       inc_req_s;
    logic       at_last_s;
`ifdef MAQH_12H_EN
    logic       pm_r;
    logic       at_eleven_s;
`endif

    maq_bcd_inc #(
        .MSD_W       (32'd2),
        .WRAP_MSD    (WRAP_MSD),
        .WRAP_LSD    (WRAP_LSD),
        .WRAP_TO_MSD (WRAP_TO_MSD),
        .WRAP_TO_LSD (WRAP_TO_LSD)
    ) u_inc (
        .msd      (msd_r),
        .lsd      (lsd_r),
        .next_msd (next_msd_s),
        .next_lsd (next_lsd_s),
        .wrap     (wrap_s)
    );

    // Increment request, last-hour-of-day detection and load digit validation.
    always_comb begin
        inc_req_s    = bus.maqh_enable | bus.maqh_adjust;
        load_valid_s = 1'b0;
`ifdef MAQH_12H_EN
        at_eleven_s = (msd_r == 2'd1) && (lsd_r == 4'd1);
        at_last_s   = at_eleven_s & pm_r;
        if ((bus.maqh_load_lsd <= 4'd9) && (bus.maqh_load_msd <= 2'd1) &&
            !((bus.maqh_load_msd == 2'd1) && (bus.maqh_load_lsd > 4'd2)) &&
            !((bus.maqh_load_msd == 2'd0) && (bus.maqh_load_lsd == 4'd0))) begin
            load_valid_s = 1'b1;
        end else begin
            load_valid_s = 1'b0;
        end
`else
        at_last_s = wrap_s;
        if ((bus.maqh_load_lsd <= 4'd9) && (bus.maqh_load_msd <= 2'(HOUR_MAX_MSD)) &&
            !((bus.maqh_load_msd == 2'(HOUR_MAX_MSD)) &&
              (bus.maqh_load_lsd > 4'(HOUR_MAX_LSD)))) begin
            load_valid_s = 1'b1;
        end else begin
            load_valid_s = 1'b0;
        end
`endif
    end

    // Day rollover is only on the minute-stage pulse; manual adjust and load never count.
    assign bus.maqh_incrementadia = bus.maqh_enable & at_last_s & ~bus.maqh_load;

    // Hour digit state: load has priority and drops any increment in the same cycle.
    always_ff @(posedge maqm_clock or posedge maqm_reset) begin
        if (maqm_reset) begin
            msd_r      <= RESET_BCD[5:4];
            lsd_r      <= RESET_BCD[3:0];
            load_err_r <= 1'b0;
`ifdef MAQH_12H_EN
            pm_r       <= RESET_PM;
`endif
        end else if (bus.maqh_load) begin
            if (load_valid_s) begin
                msd_r      <= bus.maqh_load_msd;
                lsd_r      <= bus.maqh_load_lsd;
                load_err_r <= 1'b0;
            end else begin
                load_err_r <= 1'b1;
            end
        end else begin
            load_err_r <= 1'b0;
            if (inc_req_s) begin
                msd_r <= next_msd_s;
                lsd_r <= next_lsd_s;
`ifdef MAQH_12H_EN
                // Only 11 -> 12 crosses the AM/PM boundary; 12 -> 01 does not.
                if (at_eleven_s) begin
                    pm_r <= ~pm_r;
                end else begin
                    pm_r <= pm_r;
                end
`endif
            end else begin
                msd_r <= msd_r;
                lsd_r <= lsd_r;
            end
        end
    end

    assign bus.maqh_msd      = msd_r;
    assign bus.maqh_lsd      = lsd_r;
    assign bus.maqh_load_err = load_err_r;
`ifdef MAQH_12H_EN
    assign bus.maqh_pm       = pm_r;
`endif

endmodule
